seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multi-cycle signed integer divider. It is the division counterpart to the multiplier path and its overflow detector in the mult/div unit.
- Performs one restoring-division step per clock.
- Reports quotient, remainder and an exception flag (divide-by-zero or quotient overflow).
- Uses a start/ready handshake consumed by the processor's multdiv stall logic.

Parameters:
WIDTH, 32, operand/result width in bits (two's complement); must be >= 4.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
ctrl_DIV  input  1  start pulse; operands sampled on the same edge
data_operandA  input  WIDTH  dividend (signed)
data_operandB  input  WIDTH  divisor (signed)
data_result  output  WIDTH  quotient, truncated toward zero
data_remainder  output  WIDTH  remainder; sign follows dividend, |r| < |divisor|
data_exception  output  1  divide-by-zero or overflow (MIN / -1)
data_resultRDY  output  1  one-cycle pulse: results valid
busy  output  1  high while a division is in progress

Behaviour:
- Reset:
  - Asserting reset_n low forces state IDLE and clears all outputs, the iteration counter and internal registers, immediately (async).
  - This applies mid-operation; the in-flight division is discarded with no ready pulse.
  - Deassertion takes effect at the next clock edge.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - ctrl_DIV=1 latches operands.
  - If divisor==0: go to DONE; exception=1, result=0, remainder=0.
  - Otherwise: take absolute values, record the quotient sign (signA^signB) and remainder sign (signA), clear the partial remainder, load the counter to WIDTH-1, go to CALC.
- CALC:
  - Each cycle: shift {rem,quo} left by 1, trial-subtract |B| (WIDTH+1-bit arithmetic, no truncation of the borrow).
  - If non-negative, keep the difference and set quo LSB=1; else restore and set LSB=0.
  - After WIDTH steps (counter==0), go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Overflow: dividend == -2^(WIDTH-1) and divisor == -1 → exception=1, result=0, remainder=0.
  - Go to DONE.
- DONE:
  - data_resultRDY=1 for exactly this cycle; outputs are registered and valid.
  - Next state IDLE; a ctrl_DIV sampled in DONE is accepted as a new start.
- Latency (start edge = edge 0):
  - Normal or overflow: ready high in the cycle after edge WIDTH+1, i.e. the edge WIDTH+2 samples ready=1 (34 cycles for WIDTH=32).
  - Divide-by-zero: ready high in the cycle after edge 0 (edge 1 samples ready=1).
- busy: 1 in CALC and FIX, 0 in IDLE and DONE.
- ctrl_DIV while busy is ignored; operands are not re-latched.
- data_result, data_remainder and data_exception hold their last values until the next DONE or reset. They are cleared on a new start only when that division completes.
- data_exception is meaningful only with or after ready; it is cleared by the next non-exception completion.
- The absolute value of -2^(WIDTH-1) is handled as an unsigned WIDTH-bit magnitude, so MIN / 2 etc. produce correct results.

Decomposition:
- Shared package (div_pkg):
  - WIDTH default constant.
  - state enum {IDLE, CALC, FIX, DONE}.
  - MIN_INT constant.
  - Counter width $clog2(WIDTH).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: new remainder, quotient bit.
  - Reused by the verification reference model.

Test Plan:
- 100 / 7 start at edge 0 → busy 1 from edge 1, ready pulse sampled at edge 34 only; result=14, remainder=2, exception=0.
- -100 / 7 → result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 → -14, 2; -100 / -7 → 14, -2.
- 5 / 0 → ready sampled at edge 1; exception=1, result=0, remainder=0; busy never high.
- 0x80000000 / 0xFFFFFFFF → full latency, exception=1, result=0; 0x80000000 / 2 → 0xC0000000, remainder 0, exception=0.
- reset_n low at cycle 10 of CALC → all outputs 0 asynchronously, no ready pulse; new 9 / 3 after release → 3, 0, normal latency.
- ctrl_DIV re-pulsed with 1/1 at cycle 5 of a 50/5 op → ignored, result 10; new start in DONE cycle with 7/2 → accepted, result 3, remainder 1, second ready 34 cycles later.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider:
//   DIV_WIDTH   default operand/result width
//   MIN_INT     most negative value at the default width
//   div_state_e controller states
//   cnt_width() iteration counter width for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] MIN_INT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Counter must hold WIDTH-1 (the first step index).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/ready handshake and data bus between the multdiv stall logic (master)
// and the sequential divider (slave).
//   ctrl_DIV        start pulse, operands sampled on the same edge
//   data_operandA   signed dividend
//   data_operandB   signed divisor
//   data_result     quotient, truncated toward zero
//   data_remainder  remainder, sign follows dividend
//   data_exception  divide-by-zero or MIN / -1 overflow
//   data_resultRDY  one-cycle pulse when results are valid
//   busy            division in progress
// -----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_remainder,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_DIV,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_remainder,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem       current partial remainder (always < divisor)
//   dbit      next dividend bit shifted into the remainder
//   divisor   divisor magnitude
//   rem_next  partial remainder after this step
//   qbit      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction. Because rem < divisor <= 2^(WIDTH-1), the shifted value
  // stays below 2^WIDTH, so bit WIDTH of the difference is an exact borrow.
  always_comb begin
    shifted_s = {rem, dbit};
    diff_s    = shifted_s - {1'b0, divisor};
    qbit      = ~diff_s[WIDTH];
    if (qbit) begin
      rem_next = diff_s[WIDTH-1:0];
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle signed integer divider, one restoring step per clock.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any division in flight
//   bus      seq_divider_if slave: start/ready handshake, operands, results
// Divide-by-zero completes one cycle after start; all other divisions take
// WIDTH steps plus a sign-fix cycle. Results hold until the next completion.
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  seq_divider_if.slave  bus
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH-1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  div_state_e       state_r;
  div_state_e       state_s;

  logic [WIDTH-1:0] quo_r;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] prem_r;     // partial remainder magnitude
  logic [WIDTH-1:0] absb_r;     // divisor magnitude
  logic [CW-1:0]    cnt_r;
  logic             qneg_r;
  logic             rneg_r;
  logic             ovf_r;

  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] remainder_r;
  logic             exception_r;
  logic             ready_r;
  logic             busy_r;

  logic             start_s;
  logic             divz_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] fix_quo_s;
  logic [WIDTH-1:0] fix_rem_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (prem_r),
    .dbit     (quo_r[WIDTH-1]),
    .divisor  (absb_r),
    .rem_next (step_rem_s),
    .qbit     (step_q_s)
  );

  // Start qualification and operand magnitudes. Negating MIN yields MIN, which
  // read as unsigned is the correct magnitude 2^(WIDTH-1).
  always_comb begin
    start_s = bus.ctrl_DIV & ((state_r == IDLE) | (state_r == DONE));
    divz_s  = (bus.data_operandB == ZERO);
    if (bus.data_operandA[WIDTH-1]) begin
      abs_a_s = ZERO - bus.data_operandA;
    end else begin
      abs_a_s = bus.data_operandA;
    end
    if (bus.data_operandB[WIDTH-1]) begin
      abs_b_s = ZERO - bus.data_operandB;
    end else begin
      abs_b_s = bus.data_operandB;
    end
  end

  // Sign restoration applied in FIX.
  always_comb begin
    if (qneg_r) begin
      fix_quo_s = ZERO - quo_r;
    end else begin
      fix_quo_s = quo_r;
    end
    if (rneg_r) begin
      fix_rem_s = ZERO - prem_r;
    end else begin
      fix_rem_s = prem_r;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_s) begin
          if (divz_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == DONE);
      busy_r  <= (state_s == CALC) | (state_s == FIX);
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_r       <= ZERO;
      prem_r      <= ZERO;
      absb_r      <= ZERO;
      cnt_r       <= CNT_ZERO;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      ovf_r       <= 1'b0;
      result_r    <= ZERO;
      remainder_r <= ZERO;
      exception_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_s) begin
            if (divz_s) begin
              result_r    <= ZERO;
              remainder_r <= ZERO;
              exception_r <= 1'b1;
            end else begin
              quo_r  <= abs_a_s;
              prem_r <= ZERO;
              absb_r <= abs_b_s;
              cnt_r  <= CNT_LOAD;
              qneg_r <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
              rneg_r <= bus.data_operandA[WIDTH-1];
              ovf_r  <= (bus.data_operandA == MIN_VAL) & (bus.data_operandB == ALL_ONES);
            end
          end
        end
        CALC: begin
          prem_r <= step_rem_s;
          quo_r  <= {quo_r[WIDTH-2:0], step_q_s};
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        FIX: begin
          if (ovf_r) begin
            result_r    <= ZERO;
            remainder_r <= ZERO;
            exception_r <= 1'b1;
          end else begin
            result_r    <= fix_quo_s;
            remainder_r <= fix_rem_s;
            exception_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_remainder = remainder_r;
  assign bus.data_exception = exception_r;
  assign bus.data_resultRDY = ready_r;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider: expected results are queued at start and
// compared when the ready pulse appears, including completion latency.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    int           lat;
    int           start_edge;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   edge_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input string name, input int start_edge);
    exp_t e;
    e.name       = name;
    e.start_edge = start_edge;
    if (b == {W{1'b0}}) begin
      e.res = '0; e.rem = '0; e.exc = 1'b1; e.lat = 0;
    end else if (a == MIN_INT && b == {W{1'b1}}) begin
      e.res = '0; e.rem = '0; e.exc = 1'b1; e.lat = W + 1;
    end else begin
      e.res = $signed(a) / $signed(b);
      e.rem = $signed(a) % $signed(b);
      e.exc = 1'b0;
      e.lat = W + 1;
    end
    return e;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.data_resultRDY) begin
      if (sb.size() == 0) begin
        check_val("spurious_rdy", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val({e.name, "_res"}, bus.data_result, e.res);
        check_val({e.name, "_rem"}, bus.data_remainder, e.rem);
        check_val({e.name, "_exc"}, bus.data_exception, e.exc);
        check_val({e.name, "_lat"}, edge_cnt - e.start_edge, e.lat);
        check_val({e.name, "_busy"}, bus.busy, 0);
      end
    end
  end

  // Drive a one-cycle start from a falling edge; the next rising edge is edge 0.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input string name, input bit expect_it);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (expect_it) sb.push_back(model(a, b, name, edge_cnt + 1));
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check_val({name, "_timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           n;

    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    check_val("rst_res", bus.data_result, 0);
    check_val("rst_rem", bus.data_remainder, 0);
    check_val("rst_exc", bus.data_exception, 0);
    check_val("rst_rdy", bus.data_resultRDY, 0);
    check_val("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    @(negedge clock);

    drive_start(32'd100, 32'd7, "d100_7", 1'b1);
    check_val("busy_100_7", bus.busy, 1);
    wait_idle("d100_7");
    check_val("k100_7_res", bus.data_result, 32'd14);
    check_val("k100_7_rem", bus.data_remainder, 32'd2);

    drive_start(-32'sd100, 32'd7, "dn100_7", 1'b1);
    wait_idle("dn100_7");
    check_val("kn100_7_res", bus.data_result, 32'hFFFF_FFF2);
    check_val("kn100_7_rem", bus.data_remainder, 32'hFFFF_FFFE);

    drive_start(32'd100, -32'sd7, "d100_n7", 1'b1);
    wait_idle("d100_n7");
    drive_start(-32'sd100, -32'sd7, "dn100_n7", 1'b1);
    wait_idle("dn100_n7");
    check_val("kn100_n7_res", bus.data_result, 32'd14);

    drive_start(32'd5, 32'd0, "d5_0", 1'b1);
    check_val("busy_5_0", bus.busy, 0);
    wait_idle("d5_0");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($urandom_range(1, 300)) : $urandom;
      if (i == 3) rb = -W'($urandom_range(1, 50));
      drive_start(ra, rb, "rnd", 1'b1);
      wait_idle("rnd");
    end

    drive_start(MIN_INT, 32'hFFFF_FFFF, "dmin_n1", 1'b1);
    wait_idle("dmin_n1");
    drive_start(MIN_INT, 32'd2, "dmin_2", 1'b1);
    wait_idle("dmin_2");
    check_val("kmin_2_res", bus.data_result, 32'hC000_0000);

    // Abort in the middle of CALC; results must clear immediately.
    drive_start(32'd100, 32'd3, "abort", 1'b0);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("abort_res", bus.data_result, 0);
    check_val("abort_rem", bus.data_remainder, 0);
    check_val("abort_exc", bus.data_exception, 0);
    check_val("abort_rdy", bus.data_resultRDY, 0);
    check_val("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    drive_start(32'd9, 32'd3, "d9_3", 1'b1);
    wait_idle("d9_3");

    // Re-pulse while busy is ignored; a start in the DONE cycle is accepted.
    drive_start(32'd50, 32'd5, "d50_5", 1'b1);
    repeat (4) @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd1;
    bus.data_operandB = 32'd1;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    n = 0;
    while (!bus.data_resultRDY && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("d50_5_seen", bus.data_resultRDY, 1);
    drive_start(32'd7, 32'd2, "d7_2", 1'b1);
    wait_idle("d7_2");
    check_val("k7_2_res", bus.data_result, 32'd3);
    check_val("k7_2_rem", bus.data_remainder, 32'd1);

    repeat (3) @(negedge clock);
    check_val("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
